// File: rtl/charbuf_pkg.sv
// charbuf_pkg: shared encodings and default geometry
// for the character buffer fill engine.
package charbuf_pkg;

  localparam int CB_COLS   = 80;
  localparam int CB_ROWS   = 32;
  localparam int CB_DATA_W = 7;

  typedef enum logic [1:0] {
    MODE_CLEAR  = 2'd0,
    MODE_SEQ    = 2'd1,
    MODE_REGION = 2'd2,
    MODE_SCROLL = 2'd3
  } mode_e;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_FILL   = 2'd1,
    ST_COPY   = 2'd2,
    ST_FINISH = 2'd3
  } state_e;

endpackage

// File: rtl/charbuf_region_walker.sv
// charbuf_region_walker: row-major (col,row) counter over a
// rectangle whose bounds are captured on load.
module charbuf_region_walker
  import charbuf_pkg::*;
#(
  parameter int COL_W = 7,
  parameter int ROW_W = 5
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             load,
  input  logic             advance,
  input  logic [COL_W-1:0] colLo,
  input  logic [COL_W-1:0] colHi,
  input  logic [ROW_W-1:0] rowLo,
  input  logic [ROW_W-1:0] rowHi,
  output logic [COL_W-1:0] col,
  output logic [ROW_W-1:0] row,
  output logic             first,
  output logic             last
);

  logic [COL_W-1:0] colLoQ;
  logic [COL_W-1:0] colHiQ;
  logic [ROW_W-1:0] rowLoQ;
  logic [ROW_W-1:0] rowHiQ;

  always_ff @(posedge clk) begin
    if (!resetn) begin
      colLoQ <= '0;
      colHiQ <= '0;
      rowLoQ <= '0;
      rowHiQ <= '0;
      col    <= '0;
      row    <= '0;
    end else if (load) begin
      colLoQ <= colLo;
      colHiQ <= colHi;
      rowLoQ <= rowLo;
      rowHiQ <= rowHi;
      col    <= colLo;
      row    <= rowLo;
    end else if (advance) begin
      if (col == colHiQ) begin
        col <= colLoQ;
        row <= row + 1'b1;
      end else begin
        col <= col + 1'b1;
      end
    end
  end

  assign first = (col == colLoQ) && (row == rowLoQ);
  assign last  = (col == colHiQ) && (row == rowHiQ);

endmodule

// File: rtl/charbuf_fill_engine.sv
// charbuf_fill_engine: clear/seq/region fill and scroll-up
// engine; define CHARBUF_SCROLL_EN to build the SCROLL path.
module charbuf_fill_engine
  import charbuf_pkg::*;
#(
  parameter int COLS   = CB_COLS,
  parameter int ROWS   = CB_ROWS,
  parameter int DATA_W = CB_DATA_W,
  parameter int COL_W  = $clog2(COLS),
  parameter int ROW_W  = $clog2(ROWS),
  parameter int ADDR_W = COL_W + ROW_W
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              start,
  input  logic [1:0]        mode,
  input  logic              abort,
  input  logic [DATA_W-1:0] fill_char,
  input  logic [DATA_W-1:0] seq_base,
  input  logic [ROW_W-1:0]  r0,
  input  logic [ROW_W-1:0]  r1,
  input  logic [COL_W-1:0]  c0,
  input  logic [COL_W-1:0]  c1,
  output logic              busy,
  output logic              done,
  output logic              wr_en,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [DATA_W-1:0] wr_data,
  output logic              rd_en,
  output logic [ADDR_W-1:0] rd_addr,
  input  logic [DATA_W-1:0] rd_data
);

  localparam logic [COL_W-1:0] COL_MAX = COL_W'(COLS - 1);
  localparam logic [ROW_W-1:0] ROW_MAX = ROW_W'(ROWS - 1);

  state_e state;
  state_e nxt;
  state_e scrollNext;
  mode_e  modeIn;
  mode_e  modeQ;

  logic [DATA_W-1:0] fillQ;
  logic [DATA_W-1:0] seqBaseQ;
  logic [DATA_W-1:0] seqQ;
  logic [DATA_W-1:0] seqData;

  logic [ROW_W-1:0] r1c;
  logic [COL_W-1:0] c1c;
  logic             accept;
  logic             empty;

  logic [ROW_W-1:0] fRowLo;
  logic [ROW_W-1:0] fRowHi;
  logic [COL_W-1:0] fColLo;
  logic [COL_W-1:0] fColHi;
  logic [COL_W-1:0] fCol;
  logic [ROW_W-1:0] fRow;
  logic             fFirst;
  logic             fLast;

  logic              rdDone;
  logic              pendValid;
  logic [ADDR_W-1:0] pendAddr;

  assign modeIn = mode_e'(mode);
  assign accept = (state == ST_IDLE) && start;

  assign r1c = ({1'b0, r1} > {1'b0, ROW_MAX}) ? ROW_MAX : r1;
  assign c1c = ({1'b0, c1} > {1'b0, COL_MAX}) ? COL_MAX : c1;

  assign empty = ((modeIn == MODE_REGION) ||
                  (modeIn == MODE_SCROLL)) &&
                 ((r1c < r0) || (c1c < c0));

  // SCROLL preloads the write walker with its tail row;
  // it stays parked there until COPY drains.
  always_comb begin
    fRowLo = '0;
    fRowHi = ROW_MAX;
    fColLo = '0;
    fColHi = COL_MAX;
    unique case (1'b1)
      (modeIn == MODE_REGION): begin
        fRowLo = r0;
        fRowHi = r1c;
        fColLo = c0;
        fColHi = c1c;
      end
      (modeIn == MODE_SCROLL): begin
        fRowLo = r1c;
        fRowHi = r1c;
        fColLo = c0;
        fColHi = c1c;
      end
      default: ;
    endcase
  end

  charbuf_region_walker #(
    .COL_W(COL_W),
    .ROW_W(ROW_W)
  ) uWrWalk (
    .clk    (clk),
    .resetn (resetn),
    .load   (accept),
    .advance(state == ST_FILL),
    .colLo  (fColLo),
    .colHi  (fColHi),
    .rowLo  (fRowLo),
    .rowHi  (fRowHi),
    .col    (fCol),
    .row    (fRow),
    .first  (fFirst),
    .last   (fLast)
  );

  assign seqData = fFirst ? seqBaseQ : seqQ;

  always_ff @(posedge clk) begin
    if (!resetn) begin
      modeQ    <= MODE_CLEAR;
      fillQ    <= '0;
      seqBaseQ <= '0;
      seqQ     <= '0;
    end else begin
      if (accept) begin
        modeQ    <= modeIn;
        fillQ    <= fill_char;
        seqBaseQ <= seq_base;
      end
      if (state == ST_FILL)
        seqQ <= seqData + 1'b1;
    end
  end

`ifdef CHARBUF_SCROLL_EN
  logic [COL_W-1:0] rCol;
  logic [ROW_W-1:0] rRow;
  logic             rLast;
  logic             unusedRdFirst;
  logic             rdEn;

  assign rdEn = (state == ST_COPY) && !rdDone;

  // Read pointer walks the source rows r0+1..r1.
  charbuf_region_walker #(
    .COL_W(COL_W),
    .ROW_W(ROW_W)
  ) uRdWalk (
    .clk    (clk),
    .resetn (resetn),
    .load   (accept),
    .advance(rdEn),
    .colLo  (c0),
    .colHi  (c1c),
    .rowLo  (r0 + 1'b1),
    .rowHi  (r1c),
    .col    (rCol),
    .row    (rRow),
    .first  (unusedRdFirst),
    .last   (rLast)
  );

  always_ff @(posedge clk) begin
    if (!resetn) begin
      pendValid <= 1'b0;
      pendAddr  <= '0;
      rdDone    <= 1'b0;
    end else begin
      pendValid <= rdEn && !abort;
      pendAddr  <= {rCol, rRow - 1'b1};
      if (accept)
        rdDone <= 1'b0;
      else if (rdEn && rLast)
        rdDone <= 1'b1;
    end
  end

  assign scrollNext = (r0 == r1c) ? ST_FILL : ST_COPY;
  assign rd_en      = rdEn;
  assign rd_addr    = rdEn ? {rCol, rRow} : '0;
`else
  assign rdDone     = 1'b0;
  assign pendValid  = 1'b0;
  assign pendAddr   = '0;
  assign scrollNext = ST_FINISH;
  assign rd_en      = 1'b0;
  assign rd_addr    = '0;
`endif

  always_ff @(posedge clk) begin
    if (!resetn)
      state <= ST_IDLE;
    else
      state <= nxt;
  end

  always_comb begin
    nxt = state;
    unique case (state)
      ST_IDLE: begin
        if (start) begin
          if (empty)
            nxt = ST_FINISH;
          else if (modeIn == MODE_SCROLL)
            nxt = scrollNext;
          else
            nxt = ST_FILL;
        end
      end
      ST_FILL: begin
        if (abort)
          nxt = ST_IDLE;
        else if (fLast)
          nxt = ST_FINISH;
      end
      ST_COPY: begin
        if (abort)
          nxt = ST_IDLE;
        else if (rdDone)
          nxt = ST_FILL;
      end
      ST_FINISH: nxt = ST_IDLE;
      default:   nxt = ST_IDLE;
    endcase
  end

  always_comb begin
    busy    = 1'b0;
    done    = 1'b0;
    wr_en   = 1'b0;
    wr_addr = '0;
    wr_data = '0;
    unique case (state)
      ST_FILL: begin
        busy    = 1'b1;
        wr_en   = 1'b1;
        wr_addr = {fCol, fRow};
        wr_data = (modeQ == MODE_SEQ) ? seqData : fillQ;
      end
      ST_COPY: begin
        busy    = 1'b1;
        wr_en   = pendValid;
        wr_addr = pendAddr;
        wr_data = rd_data;
      end
      ST_FINISH: done = 1'b1;
      default: ;
    endcase
  end

endmodule

// File: tb/tb_charbuf_fill_engine.sv
// tb_charbuf_fill_engine: directed bench for the fill engine
// with a small buffer RAM model on the read/write ports.
module tb_charbuf_fill_engine;

  localparam int DATA_W = 7;
  localparam int COL_W  = 7;
  localparam int ROW_W  = 5;
  localparam int ADDR_W = 12;

  logic              clk = 1'b0;
  logic              resetn = 1'b0;
  logic              start = 1'b0;
  logic [1:0]        mode = 2'd0;
  logic              abort = 1'b0;
  logic [DATA_W-1:0] fill_char = '0;
  logic [DATA_W-1:0] seq_base = '0;
  logic [ROW_W-1:0]  r0 = '0;
  logic [ROW_W-1:0]  r1 = '0;
  logic [COL_W-1:0]  c0 = '0;
  logic [COL_W-1:0]  c1 = '0;
  logic              busy;
  logic              done;
  logic              wr_en;
  logic [ADDR_W-1:0] wr_addr;
  logic [DATA_W-1:0] wr_data;
  logic              rd_en;
  logic [ADDR_W-1:0] rd_addr;
  logic [DATA_W-1:0] rd_data = '0;

  charbuf_fill_engine dut (
    .clk      (clk),
    .resetn   (resetn),
    .start    (start),
    .mode     (mode),
    .abort    (abort),
    .fill_char(fill_char),
    .seq_base (seq_base),
    .r0       (r0),
    .r1       (r1),
    .c0       (c0),
    .c1       (c1),
    .busy     (busy),
    .done     (done),
    .wr_en    (wr_en),
    .wr_addr  (wr_addr),
    .wr_data  (wr_data),
    .rd_en    (rd_en),
    .rd_addr  (rd_addr),
    .rd_data  (rd_data)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int fails  = 0;
  int cyc    = 0;

  always @(posedge clk) cyc <= cyc + 1;

  // Buffer RAM model; preload seeds cell {c,r} with r*2+c.
  logic              preload = 1'b0;
  logic [DATA_W-1:0] mem [4096];

  always @(posedge clk) begin
    if (preload) begin
      for (int a = 0; a < 4096; a++)
        mem[a] <= DATA_W'(((a % 32) * 2 + (a / 32)) % 128);
    end else begin
      if (rd_en) rd_data <= mem[rd_addr];
      if (wr_en) mem[wr_addr] <= wr_data;
    end
  end

  logic              clrLog = 1'b0;
  int                wrCount, rdCount, doneCount;
  int                doneCyc, wrFirstCyc, wrLastCyc, rdFirstCyc;
  int                copyWrites, rwBad;
  logic              doneBusy;
  logic              prevRdEn;
  logic [ADDR_W-1:0] prevRdAddr;
  logic [ADDR_W-1:0] wrAddrLog [4096];
  logic [DATA_W-1:0] wrDataLog [4096];

  always @(negedge clk) begin
    if (clrLog) begin
      wrCount    <= 0;
      rdCount    <= 0;
      doneCount  <= 0;
      doneCyc    <= -1;
      wrFirstCyc <= -1;
      wrLastCyc  <= -1;
      rdFirstCyc <= -1;
      copyWrites <= 0;
      rwBad      <= 0;
      doneBusy   <= 1'b0;
    end else begin
      if (wr_en) begin
        if (wrCount == 0) wrFirstCyc <= cyc;
        wrLastCyc <= cyc;
        if (wrCount < 4096) begin
          wrAddrLog[wrCount] <= wr_addr;
          wrDataLog[wrCount] <= wr_data;
        end
        if (prevRdEn) begin
          copyWrites <= copyWrites + 1;
          if (wr_addr !== ADDR_W'(prevRdAddr - 1))
            rwBad <= rwBad + 1;
        end
        wrCount <= wrCount + 1;
      end
      if (rd_en) begin
        if (rdCount == 0) rdFirstCyc <= cyc;
        rdCount <= rdCount + 1;
      end
      if (done) begin
        doneCount <= doneCount + 1;
        doneCyc   <= cyc;
        doneBusy  <= busy;
      end
    end
    prevRdEn   <= rd_en;
    prevRdAddr <= rd_addr;
  end

  task automatic check(input string tag,
                       input logic [31:0] obs,
                       input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  // Issues one command; acc is the cycle in which start was sampled.
  task automatic issue(input logic [1:0] m,
                       input logic [6:0] fc, input logic [6:0] sb,
                       input logic [4:0] a0, input logic [4:0] a1,
                       input logic [6:0] b0, input logic [6:0] b1,
                       output int acc);
    clrLog = 1'b1;
    tick();
    clrLog = 1'b0;
    mode = m; fill_char = fc; seq_base = sb;
    r0 = a0; r1 = a1; c0 = b0; c1 = b1;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    acc = cyc - 1;
  endtask

  task automatic waitDone();
    for (int i = 0; i < 3000; i++) begin
      if (doneCount != 0) break;
      tick();
    end
    repeat (3) tick();
  endtask

  int acc;
  int bad;
  logic pulsed;

  initial begin
    repeat (3) tick();
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_wr_en", wr_en, 0);
    check("rst_wr_addr", wr_addr, 0);
    check("rst_wr_data", wr_data, 0);
    check("rst_rd_en", rd_en, 0);
    check("rst_rd_addr", rd_addr, 0);
    resetn = 1'b1;
    repeat (2) tick();

    // CLEAR full screen with space
    issue(2'd0, 7'h20, 7'h00, 5'd0, 5'd0, 7'd0, 7'd0, acc);
    waitDone();
    check("clr_count", wrCount, 2560);
    check("clr_first_cyc", wrFirstCyc, acc + 1);
    check("clr_no_gap", wrLastCyc - wrFirstCyc, 2559);
    check("clr_first_addr", wrAddrLog[0], 0);
    check("clr_last_addr", wrAddrLog[2559], 79 * 32 + 31);
    bad = 0;
    for (int k = 0; k < 2560; k++)
      if (wrAddrLog[k] !== ADDR_W'((k % 80) * 32 + k / 80) ||
          wrDataLog[k] !== 7'h20)
        bad++;
    check("clr_order_data", bad, 0);
    check("clr_done_cyc", doneCyc, acc + 2561);
    check("clr_done_count", doneCount, 1);
    check("clr_done_busy", doneBusy, 0);

    // SEQ from 0x30, wraps at 128
    issue(2'd1, 7'h55, 7'h30, 5'd0, 5'd0, 7'd0, 7'd0, acc);
    waitDone();
    check("seq_count", wrCount, 2560);
    check("seq_w0", wrDataLog[0], 7'h30);
    check("seq_w80", wrDataLog[80], 7'h00);
    bad = 0;
    for (int k = 0; k < 2560; k++)
      if (wrDataLog[k] !== DATA_W'((48 + k) % 128)) bad++;
    check("seq_data", bad, 0);
    check("seq_done_cyc", doneCyc, acc + 2561);

    // REGION row 5, cols 10..79, then c1 clamped from 127
    for (int rep = 0; rep < 2; rep++) begin
      issue(2'd2, 7'h00, 7'h00, 5'd5, 5'd5, 7'd10,
            (rep == 0) ? 7'd79 : 7'd127, acc);
      waitDone();
      check("reg_count", wrCount, 70);
      bad = 0;
      for (int k = 0; k < 70; k++)
        if (wrAddrLog[k] !== ADDR_W'((10 + k) * 32 + 5) ||
            wrDataLog[k] !== 7'h00)
          bad++;
      check("reg_cells", bad, 0);
      check("reg_done_cyc", doneCyc, acc + 71);
    end

    // Empty region: c1 < c0
    issue(2'd2, 7'h11, 7'h00, 5'd5, 5'd5, 7'd20, 7'd10, acc);
    waitDone();
    check("empty_count", wrCount, 0);
    check("empty_done_cyc", doneCyc, acc + 1);
    check("empty_done_count", doneCount, 1);

`ifdef CHARBUF_SCROLL_EN
    preload = 1'b1;
    tick();
    preload = 1'b0;
    issue(2'd3, 7'h2a, 7'h00, 5'd0, 5'd31, 7'd0, 7'd79, acc);
    waitDone();
    check("scr_reads", rdCount, 2480);
    check("scr_writes", wrCount, 2560);
    check("scr_copy_pairs", copyWrites, 2480);
    check("scr_rw_addr", rwBad, 0);
    check("scr_first_rd", rdFirstCyc, acc + 1);
    check("scr_span", wrLastCyc - rdFirstCyc + 1, 2561);
    check("scr_done_cyc", doneCyc, wrLastCyc + 1);
    bad = 0;
    for (int c = 0; c < 80; c++)
      for (int r = 0; r < 32; r++)
        if (mem[c * 32 + r] !== ((r == 31) ? 7'h2a :
            DATA_W'(((r + 1) * 2 + c) % 128)))
          bad++;
    check("scr_contents", bad, 0);
`else
    issue(2'd3, 7'h2a, 7'h00, 5'd0, 5'd31, 7'd0, 7'd79, acc);
    waitDone();
    check("scr_off_writes", wrCount, 0);
    check("scr_off_reads", rdCount, 0);
    check("scr_off_done_cyc", doneCyc, acc + 1);
`endif

    // CLEAR aborted at write 100; restart at write 50 must be ignored
    issue(2'd0, 7'h20, 7'h00, 5'd0, 5'd0, 7'd0, 7'd0, acc);
    pulsed = 1'b0;
    for (int i = 0; i < 400; i++) begin
      if (wrCount >= 100) break;
      tick();
      if (wrCount == 50 && !pulsed) begin
        start = 1'b1; mode = 2'd1; fill_char = 7'h41;
        pulsed = 1'b1;
      end else begin
        start = 1'b0;
      end
    end
    start = 1'b0;
    abort = 1'b1;
    @(posedge clk);
    #1;
    abort = 1'b0;
    tick();
    check("abt_wr_en", wr_en, 0);
    check("abt_busy", busy, 0);
    repeat (5) tick();
    check("abt_count", wrCount, 100);
    check("abt_no_done", doneCount, 0);
    check("abt_last_addr", wrAddrLog[99], 19 * 32 + 1);
    bad = 0;
    for (int k = 0; k < 100; k++)
      if (wrDataLog[k] !== 7'h20) bad++;
    check("abt_data", bad, 0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             checks, fails);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

endmodule
